// File: rtl/csa_pkg.sv
// Shared constants and types for the bit-serial three-operand subtractor.
package csa_pkg;

    // Default operand width; the minuend carries one extra bit.
    localparam int CSA_OP_W  = 8;
    localparam int CSA_SUM_W = CSA_OP_W + 1;
    // Counter wide enough to index bits 0..OP_W.
    localparam int CSA_CNT_W = $clog2(CSA_OP_W + 1);

    // Control states of the serial engine.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Borrow subtracting two operand bits plus the borrow in never exceeds 2.
    typedef logic [1:0] borrow_t;

endpackage

// File: rtl/csa_sub_bit.sv
// One-bit three-input subtractor: t = s - b - c - borrow, with t in -4..1.
// r = t mod 2 and borrow_next = (r - t) / 2, so borrow_next stays in 0..2.
module csa_sub_bit
    import csa_pkg::*;
(
    input  logic    s,
    input  logic    b,
    input  logic    c,
    input  borrow_t borrow,
    output logic    r,
    output borrow_t borrow_next
);

    logic [2:0] sub_amt;
    logic [2:0] diff;
    logic [2:0] bn_x2;

    // Total amount taken away at this bit, then the result bit and the
    // whole-multiple-of-two borrow owed to the next bit.
    always_comb begin
        sub_amt     = {2'b00, b} + {2'b00, c} + {1'b0, borrow};
        diff        = {2'b00, s} - sub_amt;
        r           = diff[0];
        bn_x2       = sub_amt + {2'b00, diff[0]} - {2'b00, s};
        borrow_next = bn_x2[2:1];
    end

endmodule

// File: rtl/csa_sub_serial.sv
// Bit-serial recovery of a = sum - b - c_in, one result bit per cycle, LSB first.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE, and a /
// range_err hold steady until the consumer takes the result. in_valid is ignored
// outside IDLE and inputs are sampled only on the accept edge.
module csa_sub_serial
    import csa_pkg::*;
#(
    parameter int OP_W = CSA_OP_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W:0]   sum,
    input  logic [OP_W-1:0] b,
    input  logic [OP_W-1:0] c_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] a,
    output logic            range_err
);

    localparam int SUM_W = OP_W + 1;
    localparam int CNT_W = $clog2(OP_W + 1);

    state_t            state_q,  state_d;
    logic [SUM_W-1:0]  sum_q,    sum_d;
    logic [OP_W-1:0]   b_q,      b_d;
    logic [OP_W-1:0]   c_q,      c_d;
    logic [SUM_W-1:0]  res_q,    res_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    borrow_t           borrow_q, borrow_d;

    logic    r_bit;
    borrow_t borrow_nxt;

    // The single bit slice reused every RUN cycle. Once b and c have shifted
    // out, zeros fill in, so the top (sum-only) bit sees b = c = 0.
    csa_sub_bit u_bit (
        .s           (sum_q[0]),
        .b           (b_q[0]),
        .c           (c_q[0]),
        .borrow      (borrow_q),
        .r           (r_bit),
        .borrow_next (borrow_nxt)
    );

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sum_q    <= '0;
            b_q      <= '0;
            c_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= '0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            b_q      <= b_d;
            c_q      <= c_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
        end
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        b_d       = b_q;
        c_d       = c_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        borrow_d  = borrow_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sum_d    = sum;
                    b_d      = b;
                    c_d      = c_in;
                    borrow_d = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                sum_d    = sum_q >> 1;
                b_d      = b_q >> 1;
                c_d      = c_q >> 1;
                res_d    = {r_bit, res_q[SUM_W-1:1]};
                borrow_d = borrow_nxt;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(OP_W)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A set top result bit means the difference exceeded the operand range;
    // a leftover borrow means it went negative.
    assign a         = res_q[OP_W-1:0];
    assign range_err = res_q[OP_W] | (borrow_q != 2'b00);

endmodule

// File: tb/tb_csa_sub_serial.sv
// Self-checking bench for csa_sub_serial against an arithmetic reference.
module tb_csa_sub_serial;

  localparam int OP_W = 8;
  localparam int MAX_WAIT = 60;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [OP_W:0]   sum;
  logic [OP_W-1:0] b;
  logic [OP_W-1:0] c_in;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] a;
  logic            range_err;

  int checks;
  int errors;

  // expected {range_err, a}, pushed at accept, popped at result
  logic [OP_W:0] exp_q[$];

  csa_sub_serial #(.OP_W(OP_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .range_err (range_err)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // reference: true integer difference, reduced mod 2^OP_W, with range flag
  function automatic logic [OP_W:0] model(input int s, input int bb, input int cc);
    int d;
    logic [OP_W-1:0] am;
    logic err;
    d = s - bb - cc;
    am = OP_W'(d & ((1 << OP_W) - 1));
    err = (d < 0) || (d > (1 << OP_W) - 1);
    return {err, am};
  endfunction

  // present a request and wait for the accept edge; returns #1 after it
  task automatic send_req(input logic [OP_W:0] s, input logic [OP_W-1:0] bb, input logic [OP_W-1:0] cc);
    int n;
    @(negedge clk);
    sum = s;
    b = bb;
    c_in = cc;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back(model(int'(s), int'(bb), int'(cc)));
    #1;
    // scramble inputs: they must not matter after acceptance
    in_valid = 1'($urandom_range(0, 1));
    sum = (OP_W + 1)'($urandom);
    b = OP_W'($urandom);
    c_in = OP_W'($urandom);
  endtask

  // wait for the result, hold it for 'stall' cycles, then take it
  task automatic get_result(input int stall);
    int lat;
    logic [OP_W-1:0] a0;
    logic e0;
    logic [OP_W:0] exp;
    lat = 1;  // accept edge counts as the first
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(OP_W + 2));
    if (!out_valid) begin
      check("result_timeout", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      return;
    end
    a0 = a;
    e0 = range_err;
    if (exp_q.size() == 0) begin
      check("unexpected_result", 32'(exp_q.size()), 32'd1);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    check("a", 32'(a0), 32'(exp[OP_W-1:0]));
    check("range_err", 32'(e0), 32'(exp[OP_W]));
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_a", 32'(a), 32'(a0));
      check("stall_err", 32'(range_err), 32'(e0));
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [OP_W:0] s, input logic [OP_W-1:0] bb, input logic [OP_W-1:0] cc, input int stall);
    send_req(s, bb, cc);
    get_result(stall);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sum = '0;
    b = '0;
    c_in = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_a", 32'(a), 32'd0);
    check("rst_range_err", 32'(range_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // out_ready while idle does nothing
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_out_ready", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // directed cases
    run_op(9'd300, 8'd100, 8'd50, 0);
    run_op(9'd510, 8'd255, 8'd255, 0);
    run_op(9'd0, 8'd0, 8'd0, 0);
    run_op(9'd0, 8'd1, 8'd0, 0);
    run_op(9'd511, 8'd0, 8'd0, 0);
    run_op(9'd256, 8'd0, 8'd0, 1);
    run_op(9'd255, 8'd0, 8'd0, 0);
    // backpressure with in_valid toggling while held
    run_op(9'd77, 8'd200, 8'd3, 5);

    // reset in the 4th RUN cycle aborts the operation
    send_req(9'd123, 8'd45, 8'd6);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("midrst_no_pulse", 32'(n), 32'd0);
    run_op(9'd20, 8'd5, 8'd5, 0);

    // random back-to-back traffic with stalls
    for (int i = 0; i < 100; i++) begin
      run_op((OP_W + 1)'($urandom), OP_W'($urandom), OP_W'($urandom), $urandom_range(0, 3));
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
